// File: rtl/music_peak_detector_if.sv
// Stream and result bundle between the MUSIC spectrum producer and the peak detector.
// The master drives the per-angle product stream; the slave returns the held DOA results.
interface music_peak_detector_if #(
   parameter int ANGLE_W = 8,
   parameter int DATA_W  = 64
);
   logic               sweep_start;
   logic               in_av;
   logic [DATA_W-1:0]  product_theta;
   logic               busy;
   logic               done;
   logic [1:0]         peak_count;
   logic [ANGLE_W-1:0] doa0;
   logic [ANGLE_W-1:0] doa1;
   logic [DATA_W-1:0]  pmin0;
   logic [DATA_W-1:0]  pmin1;
   logic               overrun;

   modport master (
      output sweep_start, in_av, product_theta,
      input  busy, done, peak_count, doa0, doa1, pmin0, pmin1, overrun
   );

   modport slave (
      input  sweep_start, in_av, product_theta,
      output busy, done, peak_count, doa0, doa1, pmin0, pmin1, overrun
   );
endinterface

// File: rtl/music_peak_detector.sv
// Finds the two deepest interior local minima of one MUSIC product sweep
// (the pseudospectrum peaks) and holds their angles/values for the host.
module music_peak_detector #(
   parameter int NUM_ANGLES = 181,
   parameter int ANGLE_W    = 8,
   parameter int DATA_W     = 64
) (
   input logic clk,
   input logic rst,
   music_peak_detector_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COLLECT, FINAL} state_t;

   localparam logic [ANGLE_W-1:0] LAST_IDX = ANGLE_W'(NUM_ANGLES - 1);

   state_t             state, state_next;
   logic               busy, done;
   logic               accept, last_sample, is_min;
   logic [ANGLE_W-1:0] idx, cand_ang;
   logic [DATA_W-1:0]  prev1, prev2;

   logic [ANGLE_W-1:0] b0_ang, b1_ang, b0_ang_nx, b1_ang_nx;
   logic [DATA_W-1:0]  b0_val, b1_val, b0_val_nx, b1_val_nx;
   logic               b0_vld, b1_vld, b0_vld_nx, b1_vld_nx;
   logic [1:0]         cnt, cnt_nx;

   logic [1:0]         peak_count;
   logic [ANGLE_W-1:0] doa0, doa1;
   logic [DATA_W-1:0]  pmin0, pmin1;
   logic               overrun;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // A sweep_start always wins: its own strobe becomes theta 0 of the new sweep.
   always_comb begin
      state_next  = state;
      busy        = 1'b0;
      done        = 1'b0;
      accept      = bus.in_av && (bus.sweep_start || state == COLLECT);
      last_sample = accept && !bus.sweep_start && idx == LAST_IDX;
      case (state)
         IDLE: begin
            if (bus.sweep_start) state_next = COLLECT;
         end
         COLLECT: begin
            busy = 1'b1;
            if (bus.sweep_start)  state_next = COLLECT;
            else if (last_sample) state_next = FINAL;
         end
         FINAL: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = bus.sweep_start ? COLLECT : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Sample idx arriving makes idx-1 the middle of the window; a flat floor reports its first sample.
   always_comb begin
      cand_ang = idx - ANGLE_W'(1);
      is_min   = accept && !bus.sweep_start && idx >= ANGLE_W'(2) &&
                 prev1 < prev2 && prev1 <= bus.product_theta;
   end

   always_comb begin
      b0_ang_nx = b0_ang;
      b0_val_nx = b0_val;
      b0_vld_nx = b0_vld;
      b1_ang_nx = b1_ang;
      b1_val_nx = b1_val;
      b1_vld_nx = b1_vld;
      cnt_nx    = cnt;
      if (bus.sweep_start) begin
         b0_ang_nx = '0;
         b0_val_nx = '0;
         b0_vld_nx = 1'b0;
         b1_ang_nx = '0;
         b1_val_nx = '0;
         b1_vld_nx = 1'b0;
         cnt_nx    = 2'd0;
      end else if (is_min) begin
         if (!b0_vld || prev1 < b0_val) begin
            b1_ang_nx = b0_ang;
            b1_val_nx = b0_val;
            b1_vld_nx = b0_vld;
            b0_ang_nx = cand_ang;
            b0_val_nx = prev1;
            b0_vld_nx = 1'b1;
         end else if (!b1_vld || prev1 < b1_val) begin
            b1_ang_nx = cand_ang;
            b1_val_nx = prev1;
            b1_vld_nx = 1'b1;
         end
         if (cnt != 2'd2) cnt_nx = cnt + 2'd1;
      end
   end

   // Results load on the final sample's edge so they are already valid during done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx        <= '0;
         prev1      <= '0;
         prev2      <= '0;
         b0_ang     <= '0;
         b0_val     <= '0;
         b0_vld     <= 1'b0;
         b1_ang     <= '0;
         b1_val     <= '0;
         b1_vld     <= 1'b0;
         cnt        <= 2'd0;
         peak_count <= 2'd0;
         doa0       <= '0;
         doa1       <= '0;
         pmin0      <= '0;
         pmin1      <= '0;
         overrun    <= 1'b0;
      end else begin
         b0_ang <= b0_ang_nx;
         b0_val <= b0_val_nx;
         b0_vld <= b0_vld_nx;
         b1_ang <= b1_ang_nx;
         b1_val <= b1_val_nx;
         b1_vld <= b1_vld_nx;
         cnt    <= cnt_nx;
         if (bus.sweep_start) begin
            idx        <= bus.in_av ? ANGLE_W'(1) : '0;
            prev1      <= bus.in_av ? bus.product_theta : '0;
            prev2      <= '0;
            overrun    <= 1'b0;
            peak_count <= 2'd0;
         end else if (accept) begin
            idx   <= idx + ANGLE_W'(1);
            prev2 <= prev1;
            prev1 <= bus.product_theta;
         end else if (bus.in_av && state == IDLE) begin
            overrun <= 1'b1;
         end
         if (last_sample) begin
            peak_count <= cnt_nx;
            doa0       <= b0_vld_nx ? b0_ang_nx : '0;
            pmin0      <= b0_vld_nx ? b0_val_nx : '0;
            doa1       <= b1_vld_nx ? b1_ang_nx : '0;
            pmin1      <= b1_vld_nx ? b1_val_nx : '0;
         end
      end
   end

   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.peak_count = peak_count;
   assign bus.doa0       = doa0;
   assign bus.doa1       = doa1;
   assign bus.pmin0      = pmin0;
   assign bus.pmin1      = pmin1;
   assign bus.overrun    = overrun;
endmodule

// File: tb/tb_music_peak_detector.sv
// Directed bench for music_peak_detector: hand-derived sweeps with immediate-assertion checks.
module tb_music_peak_detector;
   logic clk;
   logic rst;
   int   check_count;
   int   pass_count;
   bit   early_done;
   bit   seen_done;

   music_peak_detector_if #(.ANGLE_W(8), .DATA_W(64)) bus ();

   music_peak_detector #(.NUM_ANGLES(181), .ANGLE_W(8), .DATA_W(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] sample(input int scen, input int t);
      int d;
      case (scen)
         1: begin
            d = (t <= 80) ? t - 40 : t - 120;
            if (d < 0) d = -d;
            return (t <= 80) ? 64'(d * 100 + 5) : 64'(d * 100 + 2);
         end
         2: return 64'(1000 - t);
         3: return 64'd7;
         4: return (t == 30 || t == 150 || (t >= 70 && t <= 72)) ? 64'd10 : 64'd50;
         5: return sample(1, (t + 91) % 181);
         default: return 64'd0;
      endcase
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_count++;
      assert (obs === exp) pass_count++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic start_sweep();
      @(negedge clk);
      bus.sweep_start = 1'b1;
      bus.in_av       = 1'b0;
      @(negedge clk);
      bus.sweep_start = 1'b0;
   endtask

   // Leaves the bench at the negedge right after the edge that sampled theta t_to.
   task automatic apply_stimulus(input int scen, input int t_from, input int t_to, input bit gaps);
      early_done = 1'b0;
      for (int t = t_from; t <= t_to; t++) begin
         if (bus.done) early_done = 1'b1;
         bus.in_av         = 1'b1;
         bus.product_theta = sample(scen, t);
         @(negedge clk);
         bus.in_av = 1'b0;
         if (gaps && t < t_to) begin
            repeat ($urandom_range(0, 5)) begin
               if (bus.done) early_done = 1'b1;
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic check_results(input string tag, input int pc, input int a0, input int v0,
                                input int a1, input int v1);
      check_output({tag, " early_done"}, 64'(early_done), 64'd0);
      check_output({tag, " done"}, 64'(bus.done), 64'd1);
      check_output({tag, " peak_count"}, 64'(bus.peak_count), 64'(pc));
      check_output({tag, " doa0"}, 64'(bus.doa0), 64'(a0));
      check_output({tag, " pmin0"}, bus.pmin0, 64'(v0));
      check_output({tag, " doa1"}, 64'(bus.doa1), 64'(a1));
      check_output({tag, " pmin1"}, bus.pmin1, 64'(v1));
   endtask

   initial begin
      check_count       = 0;
      pass_count        = 0;
      rst               = 1'b0;
      bus.sweep_start   = 1'b0;
      bus.in_av         = 1'b0;
      bus.product_theta = '0;
      repeat (3) @(negedge clk);
      check_output("reset busy", 64'(bus.busy), 64'd0);
      check_output("reset done", 64'(bus.done), 64'd0);
      check_output("reset peak_count", 64'(bus.peak_count), 64'd0);
      check_output("reset doa0", 64'(bus.doa0), 64'd0);
      check_output("reset pmin1", bus.pmin1, 64'd0);
      check_output("reset overrun", 64'(bus.overrun), 64'd0);
      rst = 1'b1;

      $display("[TB] scenario 1: two minima");
      start_sweep();
      check_output("s1 busy", 64'(bus.busy), 64'd1);
      apply_stimulus(1, 0, 180, 1'b0);
      check_results("s1", 2, 120, 2, 40, 5);
      check_output("s1 overrun", 64'(bus.overrun), 64'd0);
      bus.in_av = 1'b1;
      @(negedge clk);
      bus.in_av = 1'b0;
      check_output("s1 final in_av overrun", 64'(bus.overrun), 64'd0);
      check_output("s1 idle busy", 64'(bus.busy), 64'd0);
      check_output("s1 idle done", 64'(bus.done), 64'd0);
      check_output("s1 held doa0", 64'(bus.doa0), 64'd120);

      $display("[TB] scenario 2: ramp and flat");
      start_sweep();
      apply_stimulus(2, 0, 180, 1'b0);
      check_results("s2 ramp", 0, 0, 0, 0, 0);
      start_sweep();
      apply_stimulus(3, 0, 180, 1'b0);
      check_results("s2 flat", 0, 0, 0, 0, 0);

      $display("[TB] scenario 3: ties and plateau");
      start_sweep();
      apply_stimulus(4, 0, 180, 1'b0);
      check_results("s3", 2, 30, 10, 70, 10);

      $display("[TB] scenario 4: random gaps");
      start_sweep();
      apply_stimulus(1, 0, 180, 1'b1);
      check_results("s4", 2, 120, 2, 40, 5);

      $display("[TB] scenario 5: restart mid-sweep");
      start_sweep();
      apply_stimulus(1, 0, 89, 1'b0);
      bus.sweep_start   = 1'b1;
      bus.in_av         = 1'b1;
      bus.product_theta = sample(5, 0);
      @(negedge clk);
      bus.sweep_start = 1'b0;
      bus.in_av       = 1'b0;
      check_output("s5 restart busy", 64'(bus.busy), 64'd1);
      check_output("s5 restart peak_count", 64'(bus.peak_count), 64'd0);
      check_output("s5 held doa0", 64'(bus.doa0), 64'd120);
      check_output("s5 held pmin1", bus.pmin1, 64'd5);
      apply_stimulus(5, 1, 180, 1'b0);
      check_results("s5", 2, 29, 2, 130, 5);

      $display("[TB] scenario 6: reset mid-sweep and overrun");
      start_sweep();
      apply_stimulus(1, 0, 59, 1'b0);
      rst = 1'b0;
      #1;
      check_output("s6 reset busy", 64'(bus.busy), 64'd0);
      check_output("s6 reset doa0", 64'(bus.doa0), 64'd0);
      check_output("s6 reset pmin0", bus.pmin0, 64'd0);
      check_output("s6 reset peak_count", 64'(bus.peak_count), 64'd0);
      @(negedge clk);
      rst       = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_av         = 1'b1;
         bus.product_theta = 64'(i + 1);
         @(negedge clk);
         bus.in_av = 1'b0;
         if (bus.done) seen_done = 1'b1;
         if (i == 0) check_output("s6 overrun first", 64'(bus.overrun), 64'd1);
      end
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
      check_output("s6 overrun sticky", 64'(bus.overrun), 64'd1);
      check_output("s6 busy", 64'(bus.busy), 64'd0);
      check_output("s6 no done", 64'(seen_done), 64'd0);
      start_sweep();
      check_output("s6 overrun cleared", 64'(bus.overrun), 64'd0);
      check_output("s6 restart busy", 64'(bus.busy), 64'd1);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
